// File: rtl/pid_pwm_output.sv
// pid_pwm_output: converts the PID controller's signed 32-bit command into a
// saturated PWM duty plus a bridge direction bit. A new duty is taken only at
// a period boundary. A direction reversal inserts one fully blanked period so
// the bridge never changes direction while it is being driven.

module pid_pwm_output #(
    parameter int PERIOD = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_un,
    input  logic        i_valid,
    output logic        o_pwm,
    output logic        o_dir,
    output logic        o_sat,
    output logic [15:0] o_duty,
    output logic        o_period_start
);

    if ((PERIOD < 2) || (PERIOD > 65535)) begin : g_period_check
        $error("pid_pwm_output: PERIOD must lie in 2..65535");
    end

    localparam logic [15:0] PERIOD_16 = 16'(PERIOD);
    localparam logic [31:0] PERIOD_32 = 32'(PERIOD);
    localparam logic [15:0] LAST_CNT  = 16'(PERIOD - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } state_e;

    // Absolute value; the most negative input maps to 2^31 as an unsigned value.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        magnitude = v[31] ? (~v + 32'd1) : v;
    endfunction

    state_e      state_q, state_d;
    logic        started_q;
    logic [15:0] cnt_q, cnt_d;
    logic        pend_flag_q, pend_flag_d;
    logic [15:0] pend_duty_q, pend_duty_d;
    logic        pend_sat_q, pend_sat_d;
    logic        pend_dir_q, pend_dir_d;
    logic [15:0] held_duty_q, held_duty_d;
    logic        held_sat_q, held_sat_d;
    logic [15:0] duty_q, duty_d;
    logic        sat_q, sat_d;
    logic        dir_q, dir_d;
    logic        pwm_q, pwm_d;
    logic        ps_q, ps_d;

    logic [31:0] cap_mag_s;
    logic        cap_sat_s;
    logic [15:0] cap_duty_s;
    logic        cap_dir_s;
    logic        wrap_s;
    logic        src_valid_s;
    logic [15:0] src_duty_s;
    logic        src_sat_s;
    logic        src_dir_s;

    // Translate the incoming command and pick the boundary source (bypass wins over pending).
    always_comb begin
        cap_mag_s   = magnitude(i_un);
        cap_sat_s   = (cap_mag_s > PERIOD_32);
        cap_duty_s  = cap_sat_s ? PERIOD_16 : cap_mag_s[15:0];
        cap_dir_s   = i_un[31];
        wrap_s      = started_q && (cnt_q == LAST_CNT);
        src_valid_s = i_valid || pend_flag_q;
        if (i_valid) begin
            src_duty_s = cap_duty_s;
            src_sat_s  = cap_sat_s;
            src_dir_s  = cap_dir_s;
        end else begin
            src_duty_s = pend_duty_q;
            src_sat_s  = pend_sat_q;
            src_dir_s  = pend_dir_q;
        end
    end

    // Period counter; the first edge after reset starts the period at zero.
    always_comb begin
        if (!started_q) begin
            cnt_d = 16'd0;
        end else if (wrap_s) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Pending command: last pulse wins; any boundary load consumes it.
    always_comb begin
        pend_flag_d = pend_flag_q;
        pend_duty_d = pend_duty_q;
        pend_sat_d  = pend_sat_q;
        pend_dir_d  = pend_dir_q;
        if (wrap_s && src_valid_s) begin
            pend_flag_d = 1'b0;
        end else if (i_valid) begin
            pend_flag_d = 1'b1;
            pend_duty_d = cap_duty_s;
            pend_sat_d  = cap_sat_s;
            pend_dir_d  = cap_dir_s;
        end else begin
            pend_flag_d = pend_flag_q;
        end
    end

    // FSM next state: a direction mismatch at the boundary means a blanked period.
    always_comb begin
        state_d = state_q;
        if (wrap_s) begin
            case (state_q)
                ST_RUN: begin
                    if (src_valid_s && (src_dir_s != dir_q)) begin
                        state_d = ST_BLANK;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_BLANK: begin
                    if (src_valid_s && (src_dir_s != dir_q)) begin
                        state_d = ST_BLANK;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM outputs: active duty/sat/dir and the held duty parked during a blank period.
    always_comb begin
        duty_d      = duty_q;
        sat_d       = sat_q;
        dir_d       = dir_q;
        held_duty_d = held_duty_q;
        held_sat_d  = held_sat_q;
        if (wrap_s) begin
            case (state_q)
                ST_RUN: begin
                    if (!src_valid_s) begin
                        duty_d = duty_q;
                    end else if (src_dir_s == dir_q) begin
                        duty_d = src_duty_s;
                        sat_d  = src_sat_s;
                        dir_d  = src_dir_s;
                    end else begin
                        dir_d       = src_dir_s;
                        duty_d      = 16'd0;
                        sat_d       = 1'b0;
                        held_duty_d = src_duty_s;
                        held_sat_d  = src_sat_s;
                    end
                end
                ST_BLANK: begin
                    if (!src_valid_s) begin
                        duty_d = held_duty_q;
                        sat_d  = held_sat_q;
                    end else if (src_dir_s == dir_q) begin
                        duty_d = src_duty_s;
                        sat_d  = src_sat_s;
                        dir_d  = src_dir_s;
                    end else begin
                        dir_d       = src_dir_s;
                        duty_d      = 16'd0;
                        sat_d       = 1'b0;
                        held_duty_d = src_duty_s;
                        held_sat_d  = src_sat_s;
                    end
                end
                default: begin
                    duty_d = 16'd0;
                    sat_d  = 1'b0;
                end
            endcase
        end else begin
            duty_d = duty_q;
        end
        pwm_d = (cnt_d < duty_d);
        ps_d  = (cnt_d == 16'd0);
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, pending/held storage and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            started_q   <= 1'b0;
            cnt_q       <= 16'd0;
            pend_flag_q <= 1'b0;
            pend_duty_q <= 16'd0;
            pend_sat_q  <= 1'b0;
            pend_dir_q  <= 1'b0;
            held_duty_q <= 16'd0;
            held_sat_q  <= 1'b0;
            duty_q      <= 16'd0;
            sat_q       <= 1'b0;
            dir_q       <= 1'b0;
            pwm_q       <= 1'b0;
            ps_q        <= 1'b0;
        end else begin
            started_q   <= 1'b1;
            cnt_q       <= cnt_d;
            pend_flag_q <= pend_flag_d;
            pend_duty_q <= pend_duty_d;
            pend_sat_q  <= pend_sat_d;
            pend_dir_q  <= pend_dir_d;
            held_duty_q <= held_duty_d;
            held_sat_q  <= held_sat_d;
            duty_q      <= duty_d;
            sat_q       <= sat_d;
            dir_q       <= dir_d;
            pwm_q       <= pwm_d;
            ps_q        <= ps_d;
        end
    end

    assign o_pwm          = pwm_q;
    assign o_dir          = dir_q;
    assign o_sat          = sat_q;
    assign o_duty         = duty_q;
    assign o_period_start = ps_q;

endmodule

// File: tb/tb_pid_pwm_output.sv
// Bench for pid_pwm_output (PERIOD=10). The driver walks period by period
// through a directed table, pushing the hand-computed expected duty/dir/sat
// of each period; the monitor pops one entry per o_period_start and checks
// every cycle of that period.

module tb_pid_pwm_output;

    localparam int P = 10;

    logic        clk;
    logic        rst;
    logic [31:0] i_un;
    logic        i_valid;
    logic        o_pwm;
    logic        o_dir;
    logic        o_sat;
    logic [15:0] o_duty;
    logic        o_period_start;

    int checks;
    int errors;

    typedef struct packed {
        logic [15:0] duty;
        logic        dir;
        logic        sat;
    } exp_t;

    typedef struct {
        int          k1;
        logic [31:0] v1;
        int          k2;
        logic [31:0] v2;
        int          ed;
        logic        edir;
        logic        esat;
    } per_t;

    exp_t exp_q[$];
    per_t tbl[0:18];

    exp_t cur;
    int   mk;
    bit   active;

    pid_pwm_output #(.PERIOD(P)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_un           (i_un),
        .i_valid        (i_valid),
        .o_pwm          (o_pwm),
        .o_dir          (o_dir),
        .o_sat          (o_sat),
        .o_duty         (o_duty),
        .o_period_start (o_period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int d, input logic dr, input logic s);
        exp_t e;
        e.duty = 16'(d);
        e.dir  = dr;
        e.sat  = s;
        exp_q.push_back(e);
    endtask

    task automatic do_period(input per_t e);
        push_exp(e.ed, e.edir, e.esat);
        for (int k = 0; k < P; k++) begin
            i_valid = (k == e.k1) || (k == e.k2);
            i_un    = (k == e.k2) ? e.v2 : e.v1;
            tick();
        end
        i_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pwm"}, {31'd0, o_pwm}, 32'd0);
        chk({tag, "_dir"}, {31'd0, o_dir}, 32'd0);
        chk({tag, "_sat"}, {31'd0, o_sat}, 32'd0);
        chk({tag, "_duty"}, {16'd0, o_duty}, 32'd0);
        chk({tag, "_ps"}, {31'd0, o_period_start}, 32'd0);
    endtask

    // Monitor: one scoreboard entry per period, checked on every cycle.
    initial begin
        active = 1'b0;
        mk     = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else begin
                if (o_period_start) begin
                    if (active) chk("period_len", 32'(mk), 32'(P));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty actual=period_start expected=no_period_start at %0t", $time);
                        active = 1'b0;
                    end else begin
                        cur    = exp_q.pop_front();
                        active = 1'b1;
                        mk     = 0;
                    end
                end else if (active && (mk >= P)) begin
                    chk("period_len", 32'(mk), 32'(P - 1));
                    active = 1'b0;
                end
                if (active) begin
                    chk("pwm", {31'd0, o_pwm}, {31'd0, (mk < int'(cur.duty))});
                    chk("duty", {16'd0, o_duty}, {16'd0, cur.duty});
                    chk("dir", {31'd0, o_dir}, {31'd0, cur.dir});
                    chk("sat", {31'd0, o_sat}, {31'd0, cur.sat});
                    mk++;
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Driver.
    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_un    = 32'd0;

        tbl[0]  = '{4,  32'd3,          -1, 32'd0, 0,  1'b0, 1'b0};
        tbl[1]  = '{-1, 32'd0,          -1, 32'd0, 3,  1'b0, 1'b0};
        tbl[2]  = '{5,  32'h0000_0100,  -1, 32'd0, 3,  1'b0, 1'b0};
        tbl[3]  = '{9,  32'd7,          -1, 32'd0, 10, 1'b0, 1'b1};
        tbl[4]  = '{1,  32'd2,          6,  32'd6, 7,  1'b0, 1'b0};
        tbl[5]  = '{3,  32'd5,          -1, 32'd0, 6,  1'b0, 1'b0};
        tbl[6]  = '{2,  32'hFFFF_FFFC,  -1, 32'd0, 5,  1'b0, 1'b0};
        tbl[7]  = '{-1, 32'd0,          -1, 32'd0, 0,  1'b1, 1'b0};
        tbl[8]  = '{5,  32'h8000_0000,  -1, 32'd0, 4,  1'b1, 1'b0};
        tbl[9]  = '{3,  32'd0,          -1, 32'd0, 10, 1'b1, 1'b1};
        tbl[10] = '{-1, 32'd0,          -1, 32'd0, 0,  1'b0, 1'b0};
        tbl[11] = '{-1, 32'd0,          -1, 32'd0, 0,  1'b0, 1'b0};
        tbl[12] = '{4,  32'h8000_0000,  -1, 32'd0, 0,  1'b0, 1'b0};
        tbl[13] = '{2,  32'd9,          -1, 32'd0, 0,  1'b1, 1'b0};
        tbl[14] = '{-1, 32'd0,          -1, 32'd0, 0,  1'b0, 1'b0};
        tbl[15] = '{3,  32'hFFFF_FFFF,  -1, 32'd0, 9,  1'b0, 1'b0};
        tbl[16] = '{7,  32'hFFFF_FFFA,  -1, 32'd0, 0,  1'b1, 1'b0};
        tbl[17] = '{-1, 32'd0,          -1, 32'd0, 6,  1'b1, 1'b0};
        tbl[18] = '{1,  32'hFFFF_FFF8,  -1, 32'd0, 6,  1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int p = 0; p < 19; p++) begin
            do_period(tbl[p]);
        end

        // Duty 8 period; a stale pulse of 2 is pending when reset hits at k=4.
        push_exp(8, 1'b1, 1'b0);
        tick();
        tick();
        i_valid = 1'b1;
        i_un    = 32'd2;
        tick();
        i_valid = 1'b0;
        tick();
        chk("pre_reset_pwm", {31'd0, o_pwm}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("first_ps", {31'd0, o_period_start}, 32'd1);
        do_period('{-1, 32'd0, -1, 32'd0, 0, 1'b0, 1'b0});
        do_period('{-1, 32'd0, -1, 32'd0, 0, 1'b0, 1'b0});

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pid_pwm_output.md
# pid_pwm_output

Output stage fed by the PID controller's `o_un`/`o_valid` result interface. It receives each signed 32-bit control value, converts it to a saturated PWM duty and a direction bit, and drives the motor bridge. Duty changes apply only at PWM period boundaries. A direction reversal inserts one fully blanked period so the bridge never switches direction while driven.

## Interface
- `PERIOD`, default 1000: PWM period in clocks. Legal range 2..65535; out-of-range values are an elaboration error.
- `i_clk`  in  1  system clock, rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_un`  in  32  signed two's-complement control value from the PID.
- `i_valid`  in  1  one-cycle pulse; `i_un` is valid in this cycle.
- `o_pwm`  out  1  PWM drive, registered.
- `o_dir`  out  1  bridge direction: 1 = negative command, 0 = positive/zero. Registered.
- `o_sat`  out  1  high when the active duty was clamped to `PERIOD`.
- `o_duty`  out  16  active duty in clocks (0..`PERIOD`).
- `o_period_start`  out  1  high for the first clock (k=0) of every period.

## Operation
- **Capture.** On an edge where `i_valid`=1:
  - Magnitude `m` = |`i_un`|. For `i_un` = 0x8000_0000, `m` = 2^31; no wrap to negative.
  - Pending duty = min(`m`, `PERIOD`).
  - Pending sat = (`m` > `PERIOD`).
  - Pending dir = `i_un[31]`.
  - Pending flag is set.
  - Several `i_valid` pulses within one period: the last one wins.
- **Period counter.** `cnt` counts 0..`PERIOD`-1 and wraps to 0. In the cycle with `cnt`=k, `o_pwm` = (k < active duty). With duty 0, `o_pwm` stays low the whole period; with duty `PERIOD`, it stays high.
- **Boundary load (wrap edge, `cnt`=`PERIOD`-1 → 0).** The source is the pending value. If `i_valid` is high on the wrap edge itself, the incoming value bypasses the pending register and is used directly. There is no update if the pending flag is clear and `i_valid`=0. The pending flag clears whenever a load is taken.
- **State machine**, two states, evaluated at the wrap edge:
  - RUN, source dir == `o_dir`: active duty, sat and dir ← source. Stay in RUN.
  - RUN, source dir != `o_dir`: `o_dir` ← source dir. Active duty ← 0; `o_sat` ← 0. Source duty/sat are kept in a held register. Go to BLANK.
  - BLANK, pending flag clear, no `i_valid`: active duty and sat ← held values. Go to RUN.
  - BLANK, new source, same dir as `o_dir`: load it. Go to RUN.
  - BLANK, new source, dir differs from `o_dir`: flip `o_dir`, update the held values. Stay in BLANK for another period.
- `o_dir` changes only at a wrap edge, and only when entering BLANK or re-entering BLANK; it never changes while `o_pwm` could be high.
- **Reset, any time.** Counter 0, state RUN, pending and held values cleared. Outputs `o_pwm`=0, `o_dir`=0, `o_sat`=0, `o_duty`=0, `o_period_start`=0. Reset mid-period simply drops the current period; after release the first period starts at `cnt`=0.

## Timing
- After reset release:
  - The first rising edge sets `cnt`=0 state outputs. `o_period_start`=1 in that first cycle.
  - Period starts then recur every `PERIOD` clocks.
- **Best-case latency**, same direction: `i_valid` on the wrap edge → new duty visible on `o_pwm`/`o_duty` in the k=0 cycle immediately following.
- **Worst-case latency:** `i_valid` one edge after a wrap → applied `PERIOD`-1 edges later.
- **Reversal latency:** duty reaches the output one full period later than a same-direction update; the blanked period is exactly `PERIOD` clocks of `o_pwm`=0.
- **Registering:** `o_pwm`, `o_dir`, `o_sat`, `o_duty` and `o_period_start` are all registered. There is no combinational path from inputs to outputs.
- **Throughput:** accepts `i_valid` every clock; no backpressure.

## Test plan
- **Positive update:** `PERIOD`=10. Reset, then `i_valid` with `i_un`=3 → from the next k=0: `o_pwm` high for 3 clocks, low for 7, repeating; `o_dir`=0, `o_sat`=0, `o_duty`=3.
- **Saturation:** `i_un`=0x0000_0100 → `o_duty`=10, `o_pwm` constantly high, `o_sat`=1. `i_un`=0x8000_0000 → `o_duty`=10, `o_dir`=1, `o_sat`=1, preceded by one blank period.
- **Reversal:** running at +5. Apply `i_un`=-4 (0xFFFF_FFFC) → next period: `o_dir`=1, `o_pwm`=0 for 10 clocks. Following period: duty 4, `o_dir` stays 1.
- **Boundary bypass and last-wins:**
  - `i_valid` with 7 exactly on the wrap edge → k=0 of that period already uses duty 7.
  - Pulses of 2 then 6 in one period → only 6 applied.
- **Reset mid-period:** assert `i_rst` asynchronously at `cnt`=4 with duty 8 → all outputs go to 0 immediately. After release: duty 0, `o_period_start` at the first edge, and the stale pending value is not applied.
- **Zero command:** `i_un`=0 → `o_pwm` low all period, `o_dir`=0, `o_sat`=0.
